// File: rtl/wasm_pkg.sv
// Shared definitions for the WASM stack core: FSM states, opcodes, trap codes
// and per-opcode decode lookups (immediate presence, stack pops/pushes).
package wasm_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, IMM, EXEC, HALT, TRAP} state_t;

  localparam logic [7:0] OP_UNREACHABLE = 8'h00;
  localparam logic [7:0] OP_NOP         = 8'h01;
  localparam logic [7:0] OP_END         = 8'h0B;
  localparam logic [7:0] OP_DROP        = 8'h1A;
  localparam logic [7:0] OP_LOCAL_GET   = 8'h20;
  localparam logic [7:0] OP_LOCAL_SET   = 8'h21;
  localparam logic [7:0] OP_LOCAL_TEE   = 8'h22;
  localparam logic [7:0] OP_CONST       = 8'h41;
  localparam logic [7:0] OP_EQZ         = 8'h45;
  localparam logic [7:0] OP_EQ          = 8'h46;
  localparam logic [7:0] OP_ADD         = 8'h6A;
  localparam logic [7:0] OP_SUB         = 8'h6B;
  localparam logic [7:0] OP_MUL         = 8'h6C;
  localparam logic [7:0] OP_AND         = 8'h71;
  localparam logic [7:0] OP_OR          = 8'h72;
  localparam logic [7:0] OP_XOR         = 8'h73;

  localparam logic [2:0] TRAP_NONE     = 3'd0;
  localparam logic [2:0] TRAP_UNREACH  = 3'd1;
  localparam logic [2:0] TRAP_OVERFLOW = 3'd2;
  localparam logic [2:0] TRAP_UNDERFL  = 3'd3;
  localparam logic [2:0] TRAP_BAD_OP   = 3'd4;
  localparam logic [2:0] TRAP_LOCAL    = 3'd5;
  localparam logic [2:0] TRAP_OVERLONG = 3'd6;

  function automatic logic op_valid(input logic [7:0] op);
    case (op)
      OP_UNREACHABLE, OP_NOP, OP_END, OP_DROP, OP_LOCAL_GET, OP_LOCAL_SET,
      OP_LOCAL_TEE, OP_CONST, OP_EQZ, OP_EQ, OP_ADD, OP_SUB, OP_MUL,
      OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

  function automatic logic is_local(input logic [7:0] op);
    return (op == OP_LOCAL_GET) || (op == OP_LOCAL_SET) || (op == OP_LOCAL_TEE);
  endfunction

  function automatic logic needs_imm(input logic [7:0] op);
    return is_local(op) || (op == OP_CONST);
  endfunction

  function automatic logic [1:0] pops(input logic [7:0] op);
    case (op)
      OP_DROP, OP_LOCAL_SET, OP_LOCAL_TEE, OP_EQZ:                 return 2'd1;
      OP_EQ, OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR:        return 2'd2;
      default:                                                     return 2'd0;
    endcase
  endfunction

  function automatic logic pushes(input logic [7:0] op);
    case (op)
      OP_LOCAL_GET, OP_LOCAL_TEE, OP_CONST, OP_EQZ, OP_EQ,
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/leb128_decoder.sv
// LEB128 accumulator: value/done/overlong are combinational on the byte being
// presented, so the final byte is resolved in the cycle it arrives; no backpressure.
module leb128_decoder #(
  parameter int DATA_W = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        data_byte,
  output logic              done,
  output logic              overlong,
  output logic [DATA_W-1:0] value
);
  localparam int MAX_BYTES = (DATA_W + 6) / 7;
  localparam int CW        = $clog2(MAX_BYTES) + 1;

  logic [DATA_W-1:0] acc, raw, ext_mask;
  logic [CW-1:0]     cnt;
  logic [7:0]        sh, sh_next;

  always_comb begin
    sh       = 8'(cnt) * 8'd7;
    sh_next  = sh + 8'd7;
    raw      = acc | ({{(DATA_W-7){1'b0}}, data_byte[6:0]} << sh);
    // Ones above the last 7-bit group; collapses to zero once the groups fill the word.
    ext_mask = ~(({{(DATA_W-1){1'b0}}, 1'b1} << sh_next) - {{(DATA_W-1){1'b0}}, 1'b1});
    value    = (SIGNED && data_byte[6]) ? (raw | ext_mask) : raw;
    done     = byte_valid && !data_byte[7];
    overlong = byte_valid && data_byte[7] && (cnt == CW'(MAX_BYTES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (byte_valid) begin
      acc <= raw;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wasm_stack_core.sv
// Single-issue WASM stack CPU: byte-wise fetch (>=2 cycles/byte), 1-cycle execute.
// Stalls indefinitely on code_ready; start is ignored while busy.
module wasm_stack_core
  import wasm_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int STACK_DEPTH = 16,
  parameter int NUM_LOCALS  = 8,
  parameter int ADDR_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            entry_pc,
  output logic [ADDR_W-1:0]            code_addr,
  output logic                         code_rd_en,
  input  logic [7:0]                   code_rdata,
  input  logic                         code_ready,
  output logic                         busy,
  output logic                         halted,
  output logic                         trap,
  output logic [2:0]                   trap_code,
  output logic                         retired,
  output logic [$clog2(STACK_DEPTH):0] depth,
  output logic [DATA_W-1:0]            top_value
);
  localparam int SW = $clog2(STACK_DEPTH);
  localparam int DW = SW + 1;
  localparam int AW = DW + 1;
  localparam int LW = (NUM_LOCALS > 1) ? $clog2(NUM_LOCALS) : 1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic              rd_en, retired_q;
  logic [7:0]        op;
  logic [DATA_W-1:0] imm;
  logic [DW-1:0]     depth_q;
  logic [2:0]        tcode;
  logic [DATA_W-1:0] stack  [STACK_DEPTH];
  logic [DATA_W-1:0] locals [NUM_LOCALS];

  logic              byte_done, imm_byte;
  logic              s_done, s_ov, u_done, u_ov, imm_done, imm_ov;
  logic [DATA_W-1:0] s_val, u_val;

  assign byte_done = rd_en && code_ready;
  assign imm_byte  = (state == IMM) && byte_done;
  assign imm_done  = (op == OP_CONST) ? s_done : u_done;
  assign imm_ov    = (op == OP_CONST) ? s_ov   : u_ov;

  leb128_decoder #(.DATA_W(DATA_W), .SIGNED(1'b1)) u_leb_s (
    .clk(clk), .rst_n(rst_n), .clear(state == FETCH), .byte_valid(imm_byte),
    .data_byte(code_rdata), .done(s_done), .overlong(s_ov), .value(s_val)
  );
  leb128_decoder #(.DATA_W(DATA_W), .SIGNED(1'b0)) u_leb_u (
    .clk(clk), .rst_n(rst_n), .clear(state == FETCH), .byte_valid(imm_byte),
    .data_byte(code_rdata), .done(u_done), .overlong(u_ov), .value(u_val)
  );

  logic [1:0]        n_pop;
  logic              n_push;
  logic [AW-1:0]     after;
  logic [2:0]        exec_trap;
  logic [SW-1:0]     top_idx, sec_idx, wr_idx;
  logic [LW-1:0]     loc_idx;
  logic [DATA_W-1:0] top, sec, res;

  always_comb begin
    n_pop   = pops(op);
    n_push  = pushes(op);
    after   = {1'b0, depth_q} - {{(AW-2){1'b0}}, n_pop} + {{(AW-1){1'b0}}, n_push};
    top_idx = SW'(depth_q - DW'(1));
    sec_idx = SW'(depth_q - DW'(2));
    wr_idx  = SW'(after - AW'(1));
    loc_idx = imm[LW-1:0];
    top     = stack[top_idx];
    sec     = stack[sec_idx];

    exec_trap = TRAP_NONE;
    if (!op_valid(op))                                     exec_trap = TRAP_BAD_OP;
    else if (op == OP_UNREACHABLE)                         exec_trap = TRAP_UNREACH;
    else if (is_local(op) && imm >= DATA_W'(NUM_LOCALS))   exec_trap = TRAP_LOCAL;
    else if (depth_q < DW'(n_pop))                         exec_trap = TRAP_UNDERFL;
    else if (after > AW'(STACK_DEPTH))                     exec_trap = TRAP_OVERFLOW;

    case (op)
      OP_LOCAL_GET: res = locals[loc_idx];
      OP_LOCAL_TEE: res = top;
      OP_CONST:     res = imm;
      OP_EQZ:       res = {{(DATA_W-1){1'b0}}, (top == '0)};
      OP_EQ:        res = {{(DATA_W-1){1'b0}}, (sec == top)};
      OP_ADD:       res = sec + top;
      OP_SUB:       res = sec - top;
      OP_MUL:       res = sec * top;
      OP_AND:       res = sec & top;
      OP_OR:        res = sec | top;
      OP_XOR:       res = sec ^ top;
      default:      res = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, HALT, TRAP: if (start) state_nx = FETCH;
      FETCH: if (byte_done) state_nx = needs_imm(code_rdata) ? IMM : EXEC;
      IMM: begin
        if (imm_byte && imm_ov)        state_nx = TRAP;
        else if (imm_byte && imm_done) state_nx = EXEC;
      end
      EXEC: begin
        if (exec_trap != TRAP_NONE) state_nx = TRAP;
        else if (op == OP_END)      state_nx = HALT;
        else                        state_nx = FETCH;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      rd_en     <= 1'b0;
      op        <= '0;
      imm       <= '0;
      depth_q   <= '0;
      tcode     <= TRAP_NONE;
      retired_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i]  <= '0;
      for (int i = 0; i < NUM_LOCALS; i++)  locals[i] <= '0;
    end else begin
      retired_q <= 1'b0;
      case (state)
        IDLE, HALT, TRAP: if (start) begin
          pc      <= entry_pc;
          depth_q <= '0;
          tcode   <= TRAP_NONE;
          for (int i = 0; i < NUM_LOCALS; i++) locals[i] <= '0;
        end
        FETCH, IMM: begin
          // Drop the request for a cycle after every completed byte.
          if (byte_done) begin
            rd_en <= 1'b0;
            pc    <= pc + ADDR_W'(1);
            if (state == FETCH)  op    <= code_rdata;
            else if (imm_ov)     tcode <= TRAP_OVERLONG;
            else if (imm_done)   imm   <= (op == OP_CONST) ? s_val : u_val;
          end else begin
            rd_en <= 1'b1;
          end
        end
        EXEC: begin
          if (exec_trap != TRAP_NONE) begin
            tcode <= exec_trap;
          end else begin
            retired_q <= 1'b1;
            depth_q   <= DW'(after);
            if (n_push) stack[wr_idx] <= res;
            if (op == OP_LOCAL_SET || op == OP_LOCAL_TEE) locals[loc_idx] <= top;
          end
        end
        default: ;
      endcase
    end
  end

  assign code_addr  = pc;
  assign code_rd_en = rd_en;
  assign busy       = (state == FETCH) || (state == IMM) || (state == EXEC);
  assign halted     = (state == HALT);
  assign trap       = (state == TRAP);
  assign trap_code  = tcode;
  assign retired    = retired_q;
  assign depth      = depth_q;
  assign top_value  = (depth_q == '0) ? '0 : top;

endmodule

// File: tb/tb_wasm_stack_core.sv
// Directed bench for wasm_stack_core with a byte-wide code ROM responder.
module tb_wasm_stack_core;
  logic        clk, rst_n, start;
  logic [31:0] entry_pc, code_addr, top_value;
  logic        code_rd_en, code_ready, busy, halted, trap, retired;
  logic [7:0]  code_rdata;
  logic [2:0]  trap_code, depth;

  logic [7:0] mem [256];
  int  checks = 0, errors = 0, ret_cnt = 0, served = 0, serve_limit = 32'h7fffffff;
  bit  rand_en = 1'b0;
  int  r0;

  wasm_stack_core #(.DATA_W(32), .STACK_DEPTH(4), .NUM_LOCALS(8), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .entry_pc(entry_pc),
    .code_addr(code_addr), .code_rd_en(code_rd_en), .code_rdata(code_rdata),
    .code_ready(code_ready), .busy(busy), .halted(halted), .trap(trap),
    .trap_code(trap_code), .retired(retired), .depth(depth), .top_value(top_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (retired) ret_cnt <= ret_cnt + 1;

  initial begin
    int waitc, dly;
    code_ready = 1'b0; code_rdata = 8'h00; waitc = 0; dly = 0;
    forever begin
      @(negedge clk);
      if (code_ready) code_ready = 1'b0;
      else if (code_rd_en && served < serve_limit) begin
        if (waitc < dly) waitc++;
        else begin
          code_ready = 1'b1;
          code_rdata = mem[code_addr[7:0]];
          served++;
          waitc = 0;
          dly = rand_en ? int'($urandom_range(5, 0)) : 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic load(input int base, input int n, input logic [127:0] b);
    for (int i = 0; i < 256; i++) mem[i] = 8'h0B;
    for (int i = 0; i < n; i++) mem[8'(base + i)] = b[8*(n-1-i) +: 8];
  endtask

  task automatic run(input logic [31:0] pc0);
    r0 = ret_cnt;
    @(negedge clk); entry_pc = pc0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    check("run_finished_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; entry_pc = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h0B;
    #12;
    check("rst_rd_en", {63'd0, code_rd_en}, 0);
    check("rst_busy", {63'd0, busy}, 0);
    check("rst_halted", {63'd0, halted}, 0);
    check("rst_trap", {63'd0, trap}, 0);
    check("rst_depth", depth, 0);
    check("rst_top", top_value, 0);
    check("rst_addr", code_addr, 0);
    @(negedge clk); rst_n = 1'b1;

    load(0, 6, 128'h4105_4103_6A0B);
    run(0);
    check("add_halted", {63'd0, halted}, 1);
    check("add_trap", {63'd0, trap}, 0);
    check("add_trap_code", trap_code, 0);
    check("add_depth", depth, 1);
    check("add_top", top_value, 8);
    check("add_retired", ret_cnt - r0, 4);

    load(0, 7, 128'h417F_4180_016B_0B);
    run(0);
    check("sub_top", top_value, 32'hFFFFFF7F);
    check("sub_depth", depth, 1);
    rand_en = 1'b1;
    run(0);
    rand_en = 1'b0;
    check("sub_rand_top", top_value, 32'hFFFFFF7F);
    check("sub_rand_halted", {63'd0, halted}, 1);

    load(0, 10, 128'h4101_4102_2103_2003_6C0B);
    run(0);
    check("local_top", top_value, 2);
    check("local_depth", depth, 1);

    load(0, 11, 128'h4106_2200_2000_4641_076C_0B);
    run(0);
    check("tee_eq_mul_top", top_value, 7);

    load(0, 12, 128'h410C_410A_7141_0372_4105_730B);
    run(0);
    check("logic_top", top_value, 32'h0E);

    load(0, 4, 128'h4100_450B);
    run(0);
    check("eqz_top", top_value, 1);

    load(0, 2, 128'h2008);
    run(0);
    check("local_range_trap", {63'd0, trap}, 1);
    check("local_range_code", trap_code, 5);
    check("local_range_depth", depth, 0);

    load(0, 9, 128'h4100_4100_4100_4100_0B);
    run(0);
    check("full_halted", {63'd0, halted}, 1);
    check("full_depth", depth, 4);

    load(0, 10, 128'h4100_4100_4100_4100_4100);
    run(0);
    check("ovf_code", trap_code, 2);
    check("ovf_depth", depth, 4);
    check("ovf_retired", ret_cnt - r0, 4);

    load(0, 1, 128'h6A);
    run(0);
    check("unf_code", trap_code, 3);
    check("unf_depth", depth, 0);

    load(0, 7, 128'h41FF_FFFF_FFFF_01);
    run(0);
    check("overlong_code", trap_code, 6);
    check("overlong_addr", code_addr, 6);

    load(0, 1, 128'hFC);
    run(0);
    check("badop_code", trap_code, 4);

    load(0, 1, 128'h00);
    run(0);
    check("unreach_code", trap_code, 1);
    check("unreach_retired", ret_cnt - r0, 0);

    load(0, 4, 128'h4105_010B);
    serve_limit = served + 2;
    @(negedge clk); entry_pc = 32'h0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 200 && !(depth == 3'd1 && code_rd_en); i++) @(negedge clk);
    check("midread_rd_en_pre", {63'd0, code_rd_en}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midread_rd_en", {63'd0, code_rd_en}, 0);
    check("midread_depth", depth, 0);
    check("midread_busy", {63'd0, busy}, 0);
    @(negedge clk); rst_n = 1'b1; serve_limit = 32'h7fffffff;

    load(32'h40, 3, 128'h4109_0B);
    @(negedge clk); entry_pc = 32'h40; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("entry_addr", code_addr, 32'h40);
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    check("entry_top", top_value, 9);
    check("entry_halted", {63'd0, halted}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
